coin_payout: RTL and testbench
==============================

Name: coin_payout

Overview:
Output-side companion to vend_fsm. Consumes its single-cycle vend/ret10p/ret20p/ret20p2 pulses and queues them as pending work. Drives the product solenoid and the 10p/20p hopper eject lines one item at a time, using a pulse/acknowledge handshake with the hopper. Sits between vend_fsm and the physical dispense mechanism.

Parameters:
PULSE_CYCLES, 4, cycles each solenoid/eject line is held high
GAP_CYCLES, 2, minimum all-low cycles between consecutive dispense actions
CNT_W, 4, width of the pending-coin counters (max 2^CNT_W-1 queued per denomination)
ACK_TIMEOUT, 16, cycles allowed in WAIT_ACK before fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
vend  in  1  single-cycle request: dispense one product
ret10p  in  1  single-cycle request: return one 10p
ret20p  in  1  single-cycle request: return one 20p
ret20p2  in  1  single-cycle request: return two 20p
hop_ack  in  1  hopper coin-sensed pulse, one per ejected coin
prod_sol  out  1  product solenoid drive
eject10  out  1  10p hopper eject drive
eject20  out  1  20p hopper eject drive
busy  out  1  work pending or in progress
fault  out  1  sticky hopper-timeout flag
overflow  out  1  sticky request-lost flag
pend10  out  CNT_W  queued 10p count
pend20  out  CNT_W  queued 20p count

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters, product flag and timers cleared. Takes effect immediately, including mid-pulse.
- Request capture, every edge, independent of FSM state. All simultaneous requests are accepted in the same cycle:
  - vend sets prod_pend; if prod_pend is already 1, set overflow.
  - pend10 += ret10p.
  - pend20 += ret20p + 2*ret20p2.
  - Increment and service decrement apply in the same cycle as a net update.
  - A result above 2^CNT_W-1 saturates at max and sets overflow.
- FSM states: IDLE, DRIVE, WAIT_ACK, GAP, FAULT.
- IDLE: priority is prod_pend > pend20>0 > pend10>0.
  - On the selecting edge: latch kind, clear prod_pend or decrement the counter, go to DRIVE, and raise the registered drive line.
  - Latency: a request sampled at edge N raises its drive line at edge N+1 when idle and nothing else is queued.
- DRIVE: exactly one drive line is high for PULSE_CYCLES cycles.
  - Product kind then goes to GAP (no ack expected).
  - Coin kinds go to WAIT_ACK.
  - hop_ack arriving during DRIVE is latched and counts for that coin.
- WAIT_ACK: drive lines low.
  - Ack seen: go to GAP.
  - ACK_TIMEOUT cycles with no ack: go to FAULT.
  - Extra hop_ack pulses in any other state are ignored.
- GAP: all lines low for GAP_CYCLES cycles, then IDLE.
- FAULT: fault=1 and all drive lines low.
  - Requests are still accepted and counted; nothing is dispensed.
  - Only reset exits FAULT.
- busy = (state != IDLE) | prod_pend | (pend10 != 0) | (pend20 != 0).

Optional Feature:
COIN_PAYOUT_SUBST_EN
- With the macro: adds input hop20_empty. When IDLE would select a 20p while hop20_empty=1, it instead decrements pend20 and adds 2 to pend10 (saturating, overflow rules apply), then re-arbitrates on the next edge.
- Without the macro: the port is absent and 20p requests always drive eject20.

Decomposition:
- Package payout_pkg: state encoding (IDLE, DRIVE, WAIT_ACK, GAP, FAULT), kind encoding (KIND_PROD, KIND_20, KIND_10), default parameter constants.
- One sub-module, payout_timer: a loadable down-counter with a zero flag, shared by the DRIVE, GAP and timeout intervals.

Test Plan:
- vend pulse sampled at edge N -> prod_sol high from edge N+1 for 4 cycles; no eject; busy low after the 2 GAP cycles.
- ret20p2 pulse, hop_ack 2 cycles after each eject20 falls -> two 4-cycle eject20 pulses separated by at least 2 low cycles; pend20 goes 2 -> 1 -> 0.
- vend and ret10p in the same cycle -> prod_sol pulse first, then after the GAP an eject10 pulse; pend10 goes 1 -> 0.
- ret10p with no hop_ack -> fault=1 after 16 WAIT_ACK cycles. A further ret10p makes pend10=1 with eject10 staying low. rst=0 clears fault and pend10.
- 16 ret10p pulses while in FAULT -> pend10 saturates at 15 and overflow=1.
- rst=0 asserted in the 2nd cycle of an eject20 pulse -> eject20 drops immediately; all counters 0 and busy=0 after release.

Source files
------------

// File: rtl/payout_pkg.sv
// Shared types and constants for the coin_payout dispense sequencer:
// FSM state encoding, dispense-kind encoding, default interval lengths
// and the interval-to-timer-load conversion used by the top level.
package payout_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE    = 3'd1,
        WAIT_ACK = 3'd2,
        GAP      = 3'd3,
        FAULT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KIND_PROD = 2'd0,
        KIND_20   = 2'd1,
        KIND_10   = 2'd2
    } kind_e;

    localparam int DEF_PULSE_CYCLES = 4;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_CNT_W        = 4;
    localparam int DEF_ACK_TIMEOUT  = 16;

    // Interval timer width; must hold the longest interval minus one.
    localparam int TMR_W = 8;

    // The timer counts down to zero and the interval ends on the edge that
    // sees zero, so an N-cycle interval loads N-1.
    function automatic logic [TMR_W-1:0] interval_load(input int cycles);
        if (cycles > 1) begin
            return TMR_W'(cycles - 1);
        end else begin
            return {TMR_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/payout_timer.sv
// Loadable down-counter with a zero flag. One instance is shared by the
// DRIVE pulse width, the inter-dispense GAP and the hopper-ack timeout,
// since those intervals never overlap.
module payout_timer
    import payout_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority over decrement; holds at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/coin_payout.sv
// coin_payout: queues vend/return requests and dispenses them one at a time
// on the product solenoid and 10p/20p hopper eject lines, waiting for the
// hopper coin-sensed acknowledge after each coin.
// Optional build macro COIN_PAYOUT_SUBST_EN adds the hop20_empty input: an
// empty 20p hopper converts each queued 20p into two queued 10p.
module coin_payout
    import payout_pkg::*;
#(
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vend,
    input  logic             ret10p,
    input  logic             ret20p,
    input  logic             ret20p2,
    input  logic             hop_ack,
`ifdef COIN_PAYOUT_SUBST_EN
    input  logic             hop20_empty,
`endif
    output logic             prod_sol,
    output logic             eject10,
    output logic             eject20,
    output logic             busy,
    output logic             fault,
    output logic             overflow,
    output logic [CNT_W-1:0] pend10,
    output logic [CNT_W-1:0] pend20
);

    // Sum width leaves headroom for max + 3 before saturation.
    localparam int SW = CNT_W + 2;
    localparam logic [SW-1:0]    CNT_MAX_W = SW'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'((1 << CNT_W) - 1);

    state_e             state_r, state_nx_s;
    kind_e              kind_r, kind_nx_s;
    logic               prod_pend_r, prod_pend_nx_s;
    logic [CNT_W-1:0]   pend10_r, pend10_nx_s;
    logic [CNT_W-1:0]   pend20_r, pend20_nx_s;
    logic [SW-1:0]      sum10_s, sum20_s;
    logic               overflow_r, ovf_s;
    logic               ack_seen_r, clr_ack_s;
    logic               prod_sol_r, eject10_r, eject20_r;
    logic               busy_r, fault_r;
    logic               take_prod_s, take20_s, take10_s, subst_s;
    logic               empty20_s;
    logic               tmr_load_s, tmr_dec_s, tmr_zero_s;
    logic [TMR_W-1:0]   tmr_val_s;

`ifdef COIN_PAYOUT_SUBST_EN
    assign empty20_s = hop20_empty;
`else
    assign empty20_s = 1'b0;
`endif

    payout_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .dec      (tmr_dec_s),
        .zero     (tmr_zero_s)
    );

    // Next-state logic: arbitration in IDLE, interval sequencing elsewhere.
    always_comb begin
        state_nx_s  = state_r;
        kind_nx_s   = kind_r;
        take_prod_s = 1'b0;
        take20_s    = 1'b0;
        take10_s    = 1'b0;
        subst_s     = 1'b0;
        clr_ack_s   = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_dec_s   = 1'b0;
        tmr_val_s   = {TMR_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (prod_pend_r) begin
                    take_prod_s = 1'b1;
                    kind_nx_s   = KIND_PROD;
                    state_nx_s  = DRIVE;
                    clr_ack_s   = 1'b1;
                    tmr_load_s  = 1'b1;
                    tmr_val_s   = interval_load(PULSE_CYCLES);
                end else if (pend20_r != {CNT_W{1'b0}}) begin
                    if (empty20_s) begin
                        // Swap one 20p for two 10p and re-arbitrate next edge.
                        subst_s = 1'b1;
                    end else begin
                        take20_s   = 1'b1;
                        kind_nx_s  = KIND_20;
                        state_nx_s = DRIVE;
                        clr_ack_s  = 1'b1;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = interval_load(PULSE_CYCLES);
                    end
                end else if (pend10_r != {CNT_W{1'b0}}) begin
                    take10_s   = 1'b1;
                    kind_nx_s  = KIND_10;
                    state_nx_s = DRIVE;
                    clr_ack_s  = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = interval_load(PULSE_CYCLES);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DRIVE: begin
                if (tmr_zero_s) begin
                    tmr_load_s = 1'b1;
                    if (kind_r == KIND_PROD) begin
                        state_nx_s = GAP;
                        tmr_val_s  = interval_load(GAP_CYCLES);
                    end else begin
                        state_nx_s = WAIT_ACK;
                        tmr_val_s  = interval_load(ACK_TIMEOUT);
                    end
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_seen_r || hop_ack) begin
                    state_nx_s = GAP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = interval_load(GAP_CYCLES);
                end else if (tmr_zero_s) begin
                    state_nx_s = FAULT;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            GAP: begin
                if (tmr_zero_s) begin
                    state_nx_s = IDLE;
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            FAULT: begin
                state_nx_s = FAULT;
            end
            default: begin
                state_nx_s = FAULT;
            end
        endcase
    end

    // Queue update: new requests and service removals combine into one net
    // change per edge; anything past the counter maximum is dropped.
    always_comb begin
        prod_pend_nx_s = prod_pend_r;
        pend10_nx_s    = pend10_r;
        pend20_nx_s    = pend20_r;
        ovf_s          = 1'b0;

        if (vend) begin
            prod_pend_nx_s = 1'b1;
            ovf_s          = prod_pend_r & ~take_prod_s;
        end else if (take_prod_s) begin
            prod_pend_nx_s = 1'b0;
        end else begin
            prod_pend_nx_s = prod_pend_r;
        end

        sum10_s = {2'b00, pend10_r}
                + (ret10p   ? SW'(1) : SW'(0))
                + (subst_s  ? SW'(2) : SW'(0))
                - (take10_s ? SW'(1) : SW'(0));
        sum20_s = {2'b00, pend20_r}
                + (ret20p   ? SW'(1) : SW'(0))
                + (ret20p2  ? SW'(2) : SW'(0))
                - ((take20_s | subst_s) ? SW'(1) : SW'(0));

        if (sum10_s > CNT_MAX_W) begin
            pend10_nx_s = CNT_MAX;
            ovf_s       = 1'b1;
        end else begin
            pend10_nx_s = sum10_s[CNT_W-1:0];
        end

        if (sum20_s > CNT_MAX_W) begin
            pend20_nx_s = CNT_MAX;
            ovf_s       = 1'b1;
        end else begin
            pend20_nx_s = sum20_s[CNT_W-1:0];
        end
    end

    // State, queue and registered-output update; reset acts immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            kind_r      <= KIND_PROD;
            prod_pend_r <= 1'b0;
            pend10_r    <= {CNT_W{1'b0}};
            pend20_r    <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            prod_sol_r  <= 1'b0;
            eject10_r   <= 1'b0;
            eject20_r   <= 1'b0;
            busy_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            kind_r      <= kind_nx_s;
            prod_pend_r <= prod_pend_nx_s;
            pend10_r    <= pend10_nx_s;
            pend20_r    <= pend20_nx_s;
            overflow_r  <= overflow_r | ovf_s;
            prod_sol_r  <= (state_nx_s == DRIVE) && (kind_nx_s == KIND_PROD);
            eject10_r   <= (state_nx_s == DRIVE) && (kind_nx_s == KIND_10);
            eject20_r   <= (state_nx_s == DRIVE) && (kind_nx_s == KIND_20);
            busy_r      <= (state_nx_s != IDLE) | prod_pend_nx_s
                         | (pend10_nx_s != {CNT_W{1'b0}})
                         | (pend20_nx_s != {CNT_W{1'b0}});
            fault_r     <= (state_nx_s == FAULT);
        end
    end

    // Ack latch: a coin sensed while its eject line is still high counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_seen_r <= 1'b0;
        end else if (clr_ack_s) begin
            ack_seen_r <= 1'b0;
        end else if ((state_r == DRIVE) && hop_ack) begin
            ack_seen_r <= 1'b1;
        end else begin
            ack_seen_r <= ack_seen_r;
        end
    end

    assign prod_sol = prod_sol_r;
    assign eject10  = eject10_r;
    assign eject20  = eject20_r;
    assign busy     = busy_r;
    assign fault    = fault_r;
    assign overflow = overflow_r;
    assign pend10   = pend10_r;
    assign pend20   = pend20_r;

endmodule

// File: tb/tb_coin_payout.sv
// Directed self-checking bench for coin_payout (default parameters).
module tb_coin_payout;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend, ret10p, ret20p, ret20p2, hop_ack;
    logic       hop20_empty;
    logic       prod_sol, eject10, eject20, busy, fault, overflow;
    logic [3:0] pend10, pend20;

    int n_cmp = 0;
    int n_err = 0;

    coin_payout dut (
        .clk         (clk),
        .rst         (rst),
        .vend        (vend),
        .ret10p      (ret10p),
        .ret20p      (ret20p),
        .ret20p2     (ret20p2),
        .hop_ack     (hop_ack),
`ifdef COIN_PAYOUT_SUBST_EN
        .hop20_empty (hop20_empty),
`endif
        .prod_sol    (prod_sol),
        .eject10     (eject10),
        .eject20     (eject20),
        .busy        (busy),
        .fault       (fault),
        .overflow    (overflow),
        .pend10      (pend10),
        .pend20      (pend20)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick;
        tick;
        n_cmp++;
        if ({prod_sol, eject10, eject20, busy, fault, overflow, pend10, pend20} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_hold: outputs=%b expected all zero",
                     {prod_sol, eject10, eject20, busy, fault, overflow, pend10, pend20});
        end
        rst = 1'b1;
        tick;
        n_cmp++;
        if ({prod_sol, eject10, eject20, busy, fault, overflow, pend10, pend20} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_release: outputs=%b expected all zero",
                     {prod_sol, eject10, eject20, busy, fault, overflow, pend10, pend20});
        end
    endtask

    task automatic test_vend;
        vend = 1'b1;
        tick;
        vend = 1'b0;
        n_cmp++;
        if ({prod_sol, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL vend_capture: prod_sol,busy=%b expected 01", {prod_sol, busy});
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++;
            if ({prod_sol, eject10, eject20} !== 3'b100) begin
                n_err++;
                $display("FAIL vend_drive[%0d]: sol,e10,e20=%b expected 100", i,
                         {prod_sol, eject10, eject20});
            end
        end
        tick;
        n_cmp++;
        if ({prod_sol, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL vend_end: prod_sol,busy=%b expected 01", {prod_sol, busy});
        end
        tick;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL vend_gap: busy=%b expected 1", busy);
        end
        tick;
        n_cmp++;
        if ({busy, overflow} !== 2'b00) begin
            n_err++;
            $display("FAIL vend_idle: busy,overflow=%b expected 00", {busy, overflow});
        end
    endtask

    task automatic test_ret20p2;
        int lowc;
        ret20p2 = 1'b1;
        tick;
        ret20p2 = 1'b0;
        n_cmp++;
        if ({eject20, pend20} !== 5'b0_0010) begin
            n_err++;
            $display("FAIL r20_capture: eject20=%b pend20=%0d expected 0/2", eject20, pend20);
        end
        tick;
        n_cmp++;
        if ({eject20, pend20} !== 5'b1_0001) begin
            n_err++;
            $display("FAIL r20_first: eject20=%b pend20=%0d expected 1/1", eject20, pend20);
        end
        for (int i = 1; i < 4; i++) begin
            tick;
            n_cmp++;
            if (eject20 !== 1'b1) begin
                n_err++;
                $display("FAIL r20_first_hold[%0d]: eject20=%b expected 1", i, eject20);
            end
        end
        tick;
        n_cmp++;
        if (eject20 !== 1'b0) begin
            n_err++;
            $display("FAIL r20_first_fall: eject20=%b expected 0", eject20);
        end
        lowc = 1;
        for (int k = 0; k < 40 && !eject20; k++) begin
            hop_ack = (k == 1);
            tick;
            if (!eject20) lowc++;
        end
        hop_ack = 1'b0;
        n_cmp++;
        if ({eject20, pend20} !== 5'b1_0000) begin
            n_err++;
            $display("FAIL r20_second: eject20=%b pend20=%0d expected 1/0", eject20, pend20);
        end
        n_cmp++;
        if (lowc < 2) begin
            n_err++;
            $display("FAIL r20_gap: low cycles=%0d expected at least 2", lowc);
        end
        for (int i = 1; i < 4; i++) begin
            tick;
            n_cmp++;
            if (eject20 !== 1'b1) begin
                n_err++;
                $display("FAIL r20_second_hold[%0d]: eject20=%b expected 1", i, eject20);
            end
        end
        tick;
        n_cmp++;
        if (eject20 !== 1'b0) begin
            n_err++;
            $display("FAIL r20_second_fall: eject20=%b expected 0", eject20);
        end
        tick;
        hop_ack = 1'b1;
        tick;
        hop_ack = 1'b0;
        for (int k = 0; k < 30 && busy; k++) tick;
        n_cmp++;
        if ({busy, fault} !== 2'b00) begin
            n_err++;
            $display("FAIL r20_done: busy,fault=%b expected 00", {busy, fault});
        end
    endtask

    task automatic test_vend_and_ret10;
        vend   = 1'b1;
        ret10p = 1'b1;
        tick;
        vend   = 1'b0;
        ret10p = 1'b0;
        n_cmp++;
        if (pend10 !== 4'd1) begin
            n_err++;
            $display("FAIL both_capture: pend10=%0d expected 1", pend10);
        end
        tick;
        n_cmp++;
        if ({prod_sol, eject10, pend10} !== 6'b10_0001) begin
            n_err++;
            $display("FAIL both_prod_first: sol,e10=%b pend10=%0d expected 10/1",
                     {prod_sol, eject10}, pend10);
        end
        repeat (3) tick;
        tick;
        n_cmp++;
        if (prod_sol !== 1'b0) begin
            n_err++;
            $display("FAIL both_prod_fall: prod_sol=%b expected 0", prod_sol);
        end
        tick;
        tick;
        n_cmp++;
        if ({eject10, pend10} !== 5'b0_0001) begin
            n_err++;
            $display("FAIL both_gap: eject10=%b pend10=%0d expected 0/1", eject10, pend10);
        end
        tick;
        n_cmp++;
        if ({prod_sol, eject10, pend10} !== 6'b01_0000) begin
            n_err++;
            $display("FAIL both_coin: sol,e10=%b pend10=%0d expected 01/0",
                     {prod_sol, eject10}, pend10);
        end
        repeat (3) tick;
        tick;
        n_cmp++;
        if (eject10 !== 1'b0) begin
            n_err++;
            $display("FAIL both_coin_fall: eject10=%b expected 0", eject10);
        end
        tick;
        hop_ack = 1'b1;
        tick;
        hop_ack = 1'b0;
        for (int k = 0; k < 30 && busy; k++) tick;
        n_cmp++;
        if ({busy, fault} !== 2'b00) begin
            n_err++;
            $display("FAIL both_done: busy,fault=%b expected 00", {busy, fault});
        end
    endtask

    task automatic test_fault;
        ret10p = 1'b1;
        tick;
        ret10p = 1'b0;
        tick;
        n_cmp++;
        if (eject10 !== 1'b1) begin
            n_err++;
            $display("FAIL flt_drive: eject10=%b expected 1", eject10);
        end
        repeat (3) tick;
        tick;
        n_cmp++;
        if ({eject10, fault} !== 2'b00) begin
            n_err++;
            $display("FAIL flt_wait: eject10,fault=%b expected 00", {eject10, fault});
        end
        repeat (15) tick;
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL flt_early: fault=%b expected 0 after 15 wait cycles", fault);
        end
        tick;
        n_cmp++;
        if ({fault, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL flt_timeout: fault,busy=%b expected 11", {fault, busy});
        end
        ret10p = 1'b1;
        tick;
        ret10p = 1'b0;
        repeat (5) tick;
        n_cmp++;
        if ({eject10, fault, pend10} !== 6'b01_0001) begin
            n_err++;
            $display("FAIL flt_hold: e10,fault=%b pend10=%0d expected 01/1",
                     {eject10, fault}, pend10);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({fault, busy, pend10} !== 6'd0) begin
            n_err++;
            $display("FAIL flt_reset: fault,busy=%b pend10=%0d expected 00/0",
                     {fault, busy}, pend10);
        end
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_saturate;
        ret10p = 1'b1;
        tick;
        ret10p = 1'b0;
        for (int k = 0; k < 60 && !fault; k++) tick;
        n_cmp++;
        if ({fault, pend10, overflow} !== 6'b1_0000_0) begin
            n_err++;
            $display("FAIL sat_enter: fault=%b pend10=%0d overflow=%b expected 1/0/0",
                     fault, pend10, overflow);
        end
        ret10p = 1'b1;
        repeat (15) tick;
        n_cmp++;
        if ({pend10, overflow} !== 5'b1111_0) begin
            n_err++;
            $display("FAIL sat_fill: pend10=%0d overflow=%b expected 15/0", pend10, overflow);
        end
        tick;
        ret10p = 1'b0;
        n_cmp++;
        if ({pend10, overflow, eject10} !== 6'b1111_1_0) begin
            n_err++;
            $display("FAIL sat_over: pend10=%0d overflow=%b eject10=%b expected 15/1/0",
                     pend10, overflow, eject10);
        end
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid;
        ret20p = 1'b1;
        ret10p = 1'b1;
        tick;
        ret20p = 1'b0;
        ret10p = 1'b0;
        tick;
        n_cmp++;
        if ({eject20, pend10, pend20} !== 9'b1_0001_0000) begin
            n_err++;
            $display("FAIL mid_first: eject20=%b pend10=%0d pend20=%0d expected 1/1/0",
                     eject20, pend10, pend20);
        end
        tick;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({eject20, busy, pend10, pend20} !== 10'd0) begin
            n_err++;
            $display("FAIL mid_async: eject20,busy=%b pend10=%0d pend20=%0d expected 00/0/0",
                     {eject20, busy}, pend10, pend20);
        end
        tick;
        rst = 1'b1;
        tick;
        tick;
        n_cmp++;
        if ({prod_sol, eject10, eject20, busy, fault, overflow, pend10, pend20} !== 14'd0) begin
            n_err++;
            $display("FAIL mid_release: outputs=%b expected all zero",
                     {prod_sol, eject10, eject20, busy, fault, overflow, pend10, pend20});
        end
    endtask

    initial begin
        rst         = 1'b0;
        vend        = 1'b0;
        ret10p      = 1'b0;
        ret20p      = 1'b0;
        ret20p2     = 1'b0;
        hop_ack     = 1'b0;
        hop20_empty = 1'b0;
        test_reset;
        test_vend;
        test_ret20p2;
        test_vend_and_ret10;
        test_fault;
        test_saturate;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
